neuron_buffer_swap_ctrl: RTL and testbench

- Sequencer that drives the ping-pong neuron buffer swapper.
- Generates the `readBufferSelect`, `readBuffAddress` and `writeBuffAddress` consumed by the swapper.
- Handshakes with the conv unit (reader of the read buffer) and the pool unit (writer of the write buffer).
- Swaps buffer roles only when the read pass and the write pass are both complete; repeats for a programmed number of passes (layers).

---
 rtl/neuron_buffer_swap_ctrl.sv | 151 +++++++++++++++
 tb/tb_neuron_buffer_swap_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_buffer_swap_ctrl.sv
// Ping-pong neuron buffer sequencer: drives read/write addresses and the buffer-role select,
// and swaps roles once both passes finish. NBUF_STALL_COUNT_EN adds a one-sided stall counter.
module neuron_buffer_swap_ctrl #(
  parameter int unsigned depth = 2,
  parameter int unsigned A     = 7,
  parameter int unsigned P     = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [A:0]   numReads,
  input  logic [A:0]   numWrites,
  input  logic [P-1:0] numPasses,
  input  logic         rdReq,
  output logic         rdValid,
  input  logic         wrValid,
  output logic         wrReady,
  output logic         writeEnable,
  output logic         readBufferSelect,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic [P-1:0] passIndex,
  output logic         busy,
  output logic         done
`ifdef NBUF_STALL_COUNT_EN
  ,
  output logic [15:0]  stallCycles
`endif
);

  // depth only documents the swapper lane count; nothing here depends on it.
  if (depth < 32) begin : g_depth_ok
  end

  typedef enum logic [1:0] {StIdle, StRun, StSwap} state_e;

  state_e state_q, state_d;

  logic [A:0]   rd_cnt_q, wr_cnt_q;
  logic [A:0]   num_reads_q, num_writes_q;
  logic [P-1:0] num_passes_q, pass_q;
  logic [A-1:0] rd_addr_q;
  logic         sel_q;
  logic         rd_issued_q;
  logic         rd_valid_q;
  logic         done_q;

  logic rd_done, wr_done, rd_accept, wr_ready, last_pass, start_acc, run_exit;

  always_comb begin
    rd_done   = (rd_cnt_q == num_reads_q);
    wr_done   = (wr_cnt_q == num_writes_q);
    rd_accept = (state_q == StRun) && rdReq && (rd_cnt_q < num_reads_q);
    wr_ready  = (state_q == StRun) && (wr_cnt_q < num_writes_q);
    last_pass = (pass_q == (num_passes_q - P'(1)));
    start_acc = (state_q == StIdle) && start;
    // The last accepted read must have shown its rdValid before the roles flip.
    run_exit  = (state_q == StRun) && rd_done && wr_done && !rd_issued_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (run_exit) state_d = StSwap;
      StSwap:  state_d = last_pass ? StIdle : StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      num_reads_q  <= '0;
      num_writes_q <= '0;
      num_passes_q <= '0;
      pass_q       <= '0;
      rd_addr_q    <= '0;
      sel_q        <= 1'b0;
      rd_issued_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= 1'b0;
      rd_issued_q <= rd_accept;
      rd_valid_q  <= rd_issued_q;

      if (start_acc) begin
        num_reads_q  <= numReads;
        num_writes_q <= numWrites;
        num_passes_q <= (numPasses == '0) ? P'(1) : numPasses;
        rd_cnt_q     <= '0;
        wr_cnt_q     <= '0;
        pass_q       <= '0;
      end

      if (rd_accept) begin
        rd_addr_q <= rd_cnt_q[A-1:0];
        rd_cnt_q  <= rd_cnt_q + (A+1)'(1);
      end

      if (wrValid && wr_ready) begin
        wr_cnt_q <= wr_cnt_q + (A+1)'(1);
      end

      // Role flip and counter clear take effect as SWAP is entered.
      if (run_exit) begin
        sel_q     <= ~sel_q;
        rd_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        rd_addr_q <= '0;
      end

      if (state_q == StSwap) begin
        if (last_pass) begin
          done_q <= 1'b1;
        end else begin
          pass_q <= pass_q + P'(1);
        end
      end
    end
  end

`ifdef NBUF_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK) begin
    if (reset || start_acc) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && (rd_done ^ wr_done) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stallCycles = stall_q;
`endif

  assign rdValid          = rd_valid_q;
  assign wrReady          = wr_ready;
  assign writeEnable      = wrValid && wr_ready;
  assign readBufferSelect = sel_q;
  assign readBuffAddress  = rd_addr_q;
  assign writeBuffAddress = wr_cnt_q[A-1:0];
  assign passIndex        = pass_q;
  assign busy             = (state_q != StIdle);
  assign done             = done_q;

endmodule

// File: tb/tb_neuron_buffer_swap_ctrl.sv
// Bench for neuron_buffer_swap_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model of passes, counts and buffer roles.
module tb_neuron_buffer_swap_ctrl;
  localparam int unsigned A = 7;
  localparam int unsigned P = 8;
  localparam int Words = 128;
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MSwap = 2;

  logic         CLK = 1'b0;
  logic         reset, start, rdReq, wrValid;
  logic [A:0]   numReads, numWrites;
  logic [P-1:0] numPasses;
  logic         rdValid, wrReady, writeEnable, readBufferSelect, busy, done;
  logic [A-1:0] readBuffAddress, writeBuffAddress;
  logic [P-1:0] passIndex;
`ifdef NBUF_STALL_COUNT_EN
  logic [15:0]  stallCycles;
`endif

  always #5 CLK = ~CLK;

  neuron_buffer_swap_ctrl #(.depth(2), .A(A), .P(P)) dut (
    .CLK(CLK), .reset(reset), .start(start), .numReads(numReads), .numWrites(numWrites),
    .numPasses(numPasses), .rdReq(rdReq), .rdValid(rdValid), .wrValid(wrValid),
    .wrReady(wrReady), .writeEnable(writeEnable), .readBufferSelect(readBufferSelect),
    .readBuffAddress(readBuffAddress), .writeBuffAddress(writeBuffAddress),
    .passIndex(passIndex), .busy(busy), .done(done)
`ifdef NBUF_STALL_COUNT_EN
    , .stallCycles(stallCycles)
`endif
  );

  int checks = 0, errors = 0;
  int done_seen = 0, rv_seen = 0, max_pass = 0;
  // Reference model: which phase we are in, words moved per side, pass bookkeeping.
  int m_mode = MIdle, m_rd = 0, m_wr = 0, m_nr = 0, m_nw = 0, m_np = 1, m_pass = 0;
  int m_sel = 0, m_raddr = 0, m_iss = 0, m_rv = 0, m_done = 0, m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int acc, wen, fin, rdy;
    #1;
    rdy = (m_mode == MRun && m_wr < m_nw) ? 1 : 0;
    check("wrReady", 32'(wrReady), 32'(rdy));
    check("writeEnable", 32'(writeEnable), 32'(rdy != 0 && wrValid));
    check("writeBuffAddress", 32'(writeBuffAddress), 32'(m_wr % Words));
    if (reset) begin
      m_mode = MIdle; m_rd = 0; m_wr = 0; m_pass = 0; m_sel = 0; m_raddr = 0;
      m_iss = 0; m_rv = 0; m_done = 0; m_stall = 0; m_nr = 0; m_nw = 0; m_np = 1;
    end else begin
      m_done = 0;
      acc = (m_mode == MRun && rdReq && m_rd < m_nr) ? 1 : 0;
      wen = (rdy != 0 && wrValid) ? 1 : 0;
      fin = (m_mode == MRun && m_rd == m_nr && m_wr == m_nw && m_iss == 0) ? 1 : 0;
      if (m_mode == MRun && ((m_rd == m_nr) != (m_wr == m_nw)) && m_stall < 65535) m_stall++;
      m_rv  = m_iss;
      m_iss = acc;
      case (m_mode)
        MIdle: if (start) begin
          m_nr = int'(numReads); m_nw = int'(numWrites);
          m_np = (numPasses == 0) ? 1 : int'(numPasses);
          m_rd = 0; m_wr = 0; m_pass = 0; m_stall = 0; m_mode = MRun;
        end
        MRun: begin
          if (acc != 0) begin m_raddr = m_rd % Words; m_rd++; end
          if (wen != 0) m_wr++;
          if (fin != 0) begin
            m_mode = MSwap; m_sel = m_sel ^ 1; m_rd = 0; m_wr = 0; m_raddr = 0;
          end
        end
        default: if (m_pass == m_np - 1) begin
          m_mode = MIdle; m_done = 1;
        end else begin
          m_pass++; m_mode = MRun;
        end
      endcase
    end
    @(posedge CLK);
    #1;
    check("rdValid", 32'(rdValid), 32'(m_rv));
    check("readBufferSelect", 32'(readBufferSelect), 32'(m_sel));
    check("readBuffAddress", 32'(readBuffAddress), 32'(m_raddr));
    check("passIndex", 32'(passIndex), 32'(m_pass));
    check("busy", 32'(busy), 32'(m_mode != MIdle));
    check("done", 32'(done), 32'(m_done));
`ifdef NBUF_STALL_COUNT_EN
    check("stallCycles", 32'(stallCycles), 32'(m_stall));
`endif
    if (done) done_seen++;
    if (rdValid) rv_seen++;
    if (int'(passIndex) > max_pass) max_pass = int'(passIndex);
  endtask

  task automatic launch(input int nr, input int nw, input int np);
    numReads = (A+1)'(nr); numWrites = (A+1)'(nw); numPasses = P'(np);
    done_seen = 0; rv_seen = 0; max_pass = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int limit);
    int i;
    i = 0;
    while (m_mode != MIdle && i < limit) begin
      tick();
      i++;
    end
    if (m_mode != MIdle) check("timeout_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rdReq = 1'b0; wrValid = 1'b0;
    numReads = '0; numWrites = '0; numPasses = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single pass, equal counts, both sides streaming.
    rdReq = 1'b1; wrValid = 1'b1;
    launch(4, 4, 1);
    run_to_idle(100);
    check("single_done_count", 32'(done_seen), 32'(1));
    check("single_rdvalid_count", 32'(rv_seen), 32'(4));
    check("single_sel_final", 32'(readBufferSelect), 32'(1));

    // Reset after two reads of pass 0 aborts and returns the select to 0.
    launch(4, 4, 2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_sel", 32'(readBufferSelect), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done_count", 32'(done_seen), 32'(0));
    tick();

    // Unequal sides over three passes.
    launch(8, 2, 3);
    run_to_idle(200);
    check("unequal_done_count", 32'(done_seen), 32'(1));
    check("unequal_sel_final", 32'(readBufferSelect), 32'(1));
    check("unequal_max_pass", 32'(max_pass), 32'(2));
    check("unequal_reads", 32'(rv_seen), 32'(24));
`ifdef NBUF_STALL_COUNT_EN
    check("unequal_stall", 32'(stallCycles), 32'(18));
`endif

    // Read backpressure, no writes; extra requests after three reads are ignored.
    wrValid = 1'b0;
    launch(3, 0, 1);
    rdReq = 1'b1; tick();
    rdReq = 1'b0; tick();
    rdReq = 1'b1; tick();
    rdReq = 1'b0; tick();
    rdReq = 1'b1;
    run_to_idle(100);
    check("bp_reads", 32'(rv_seen), 32'(3));
    check("bp_sel_final", 32'(readBufferSelect), 32'(0));

    // Zero counts: one RUN cycle, one SWAP cycle, then done.
    rdReq = 1'b1; wrValid = 1'b1;
    launch(0, 0, 0);
    check("zero_busy", 32'(busy), 32'(1));
    tick();
    check("zero_no_done_yet", 32'(done), 32'(0));
    tick();
    check("zero_done", 32'(done), 32'(1));
    check("zero_sel", 32'(readBufferSelect), 32'(1));
    check("zero_reads", 32'(rv_seen), 32'(0));

    // Second start mid-run with different counts has no effect.
    launch(5, 3, 2);
    tick();
    tick();
    numReads = (A+1)'(1); numWrites = (A+1)'(7); numPasses = P'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_idle(200);
    check("restart_reads", 32'(rv_seen), 32'(10));
    check("restart_done_count", 32'(done_seen), 32'(1));
    check("restart_sel", 32'(readBufferSelect), 32'(1));

    // Random traffic, with occasional stray starts and rare resets.
    for (int t = 0; t < 25; t++) begin
      launch(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 3)));
      for (int i = 0; i < 3000 && m_mode != MIdle; i++) begin
        rdReq   = 1'($urandom_range(0, 1));
        wrValid = 1'($urandom_range(0, 1));
        start   = ($urandom_range(0, 15) == 0);
        reset   = ($urandom_range(0, 299) == 0);
        if (start) numReads = (A+1)'($urandom_range(0, 20));
        tick();
        reset = 1'b0;
      end
      start = 1'b0;
      if (m_mode != MIdle) check("random_timeout_busy", 32'(busy), 32'(0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
